// File: rtl/tt_mux_pkg.sv
// Shared widths, field offsets and FSM state type for the project-select mux.
package tt_mux_pkg;

    localparam int IW_W = 18;  // {uio_in, ui_in, rst_n, clk}
    localparam int OW_W = 24;  // {uio_oe, uio_out, uo_out}

    // Input word field offsets
    localparam int IW_CLK  = 0;
    localparam int IW_RSTN = 1;
    localparam int IW_UI   = 2;
    localparam int IW_UIO  = 10;

    // Output word field offsets
    localparam int OW_UO      = 0;
    localparam int OW_UIO_OUT = 8;
    localparam int OW_UIO_OE  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        ACTIVE
    } sel_state_t;

endpackage

// File: rtl/tt_prj_sel_ctrl_if.sv
// Pad/project bus between the select controller and the wrapper array.
// slave: the controller side; master: pads + project wrappers.
interface tt_prj_sel_ctrl_if #(
    parameter int N_PROJ = 8
);
    import tt_mux_pkg::*;

    logic [IW_W-1:0]        pad_iw;
    logic [N_PROJ*OW_W-1:0] prj_ow;
    logic [IW_W-1:0]        prj_iw;
    logic [N_PROJ-1:0]      prj_ena;
    logic [OW_W-1:0]        pad_ow;

    modport slave (
        input  pad_iw,
        input  prj_ow,
        output prj_iw,
        output prj_ena,
        output pad_ow
    );

    modport master (
        output pad_iw,
        output prj_ow,
        input  prj_iw,
        input  prj_ena,
        input  pad_ow
    );

endinterface

// File: rtl/tt_ctrl_sync.sv
// 2-FF synchroniser for an asynchronous pad strobe. RISE=1 turns the
// synchronised level into a one-clk pulse on its rising edge.
module tt_ctrl_sync #(
    parameter bit RISE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    // Two-stage metastability filter
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], async_i};
    end

    if (RISE) begin : g_rise
        logic dly_q;

        // Delayed copy of the synchronised level for edge detection
        always_ff @(posedge clk) begin
            if (rst) dly_q <= 1'b0;
            else     dly_q <= sync_q[1];
        end

        assign sync_o = sync_q[1] & ~dly_q;
    end else begin : g_lvl
        assign sync_o = sync_q[1];
    end

endmodule

// File: rtl/tt_prj_sel_ctrl.sv
// Project-select controller: decodes pad strobes into a select counter and a
// one-hot wrapper enable, broadcasts the pad input word, muxes the selected
// project's output word back to the pads.
// Build option: TT_OW_REG_EN registers pad_ow (one clk latency).
module tt_prj_sel_ctrl
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ     = 8,
    parameter int ADDR_W     = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_sel_rst,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    tt_prj_sel_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] cur_sel,
    output logic              active
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic sel_rst_s, inc_s, ena_s;

    tt_ctrl_sync #(.RISE(1'b0)) u_sync_rst (
        .clk(clk), .rst(rst), .async_i(ctrl_sel_rst), .sync_o(sel_rst_s)
    );
    tt_ctrl_sync #(.RISE(1'b1)) u_sync_inc (
        .clk(clk), .rst(rst), .async_i(ctrl_sel_inc), .sync_o(inc_s)
    );
    tt_ctrl_sync #(.RISE(1'b0)) u_sync_ena (
        .clk(clk), .rst(rst), .async_i(ctrl_ena), .sync_o(ena_s)
    );

    sel_state_t        state_q;
    logic [ADDR_W-1:0] cur_sel_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              block_q;   // set on any select change; cleared once ena drops
    logic [N_PROJ-1:0] prj_ena_q;
    logic              active_q;

    logic [N_PROJ-1:0] onehot;
    logic [OW_W-1:0]   sel_ow;
    logic              sel_valid;

    // Extra top bit keeps the compare correct when N_PROJ == 2^ADDR_W
    assign sel_valid = {1'b0, cur_sel_q} < (ADDR_W+1)'(N_PROJ);

    // Decode the select counter into a slot mask and pick that slot's output word
    always_comb begin
        onehot = '0;
        sel_ow = '0;
        for (int k = 0; k < N_PROJ; k++) begin
            if (cur_sel_q == ADDR_W'(k)) begin
                onehot[k] = 1'b1;
                sel_ow    = bus.prj_ow[k*OW_W +: OW_W];
            end
        end
    end

    // Select counter and IDLE/ARMING/ACTIVE sequencing; priority sel_rst > inc > ena
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            cnt_q     <= '0;
            block_q   <= 1'b0;
            prj_ena_q <= '0;
            active_q  <= 1'b0;
        end else if (sel_rst_s) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            cnt_q     <= '0;
            block_q   <= 1'b1;
            prj_ena_q <= '0;
            active_q  <= 1'b0;
        end else if (inc_s) begin
            if (cur_sel_q != '1) cur_sel_q <= cur_sel_q + ADDR_W'(1);
            state_q   <= IDLE;
            cnt_q     <= '0;
            block_q   <= 1'b1;
            prj_ena_q <= '0;
            active_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!ena_s) begin
                        block_q <= 1'b0;
                    end else if (!block_q && sel_valid) begin
                        if (SETTLE_CYC == 1) begin
                            state_q   <= ACTIVE;
                            prj_ena_q <= onehot;
                            active_q  <= 1'b1;
                        end else begin
                            state_q <= ARMING;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (!ena_s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        state_q   <= ACTIVE;
                        cnt_q     <= '0;
                        prj_ena_q <= onehot;
                        active_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (!ena_s) begin
                        state_q   <= IDLE;
                        prj_ena_q <= '0;
                        active_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.prj_ena = prj_ena_q;
    assign cur_sel     = cur_sel_q;
    assign active      = active_q;

    // Unselected projects see clk=0 and rst_n=0
    assign bus.prj_iw = active_q ? bus.pad_iw : '0;

`ifdef TT_OW_REG_EN
    logic [OW_W-1:0] pad_ow_q;
    logic [OW_W-1:0] pad_ow_d;

    assign pad_ow_d = active_q ? sel_ow : '0;

    // Retime the pad output word; clears one clk after active falls
    always_ff @(posedge clk) begin
        if (rst) pad_ow_q <= '0;
        else     pad_ow_q <= pad_ow_d;
    end

    assign bus.pad_ow = pad_ow_q;
`else
    assign bus.pad_ow = active_q ? sel_ow : '0;
`endif

endmodule

// File: tb/tb_tt_prj_sel_ctrl.sv
// Directed self-checking bench for tt_prj_sel_ctrl (honours TT_OW_REG_EN).
module tb_tt_prj_sel_ctrl;

    localparam int N_PROJ = 8;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              ctrl_sel_rst;
    logic              ctrl_sel_inc;
    logic              ctrl_ena;
    logic [ADDR_W-1:0] cur_sel;
    logic              active;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];
    logic [8:0]  seen;

    tt_prj_sel_ctrl_if #(.N_PROJ(N_PROJ)) bus ();

    tt_prj_sel_ctrl #(.N_PROJ(N_PROJ), .ADDR_W(ADDR_W), .SETTLE_CYC(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_sel_rst (ctrl_sel_rst),
        .ctrl_sel_inc (ctrl_sel_inc),
        .ctrl_ena     (ctrl_ena),
        .bus          (bus),
        .cur_sel      (cur_sel),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic inc_pulse();
        ctrl_sel_inc = 1'b1; tick(2);
        ctrl_sel_inc = 1'b0; tick(2);
    endtask

    task automatic selrst_pulse();
        ctrl_sel_rst = 1'b1; tick(3);
        ctrl_sel_rst = 1'b0; tick(3);
    endtask

    // Drive fresh project words, queue the expected pad word, compare after latency
    task automatic ow_step(input string tag, input int slot);
        logic [N_PROJ*24-1:0] w;
        logic [23:0] e;
        for (int k = 0; k < N_PROJ; k++) w[k*24 +: 24] = 24'($urandom);
        bus.prj_ow = w;
        e = '0;
        if (slot >= 0) e = w[slot*24 +: 24];
        exp_q.push_back(e);
`ifdef TT_OW_REG_EN
        tick(1);
`else
        #1;
`endif
        chk(tag, 32'(bus.pad_ow), 32'(exp_q.pop_front()));
    endtask

    task automatic iw_step(input string tag, input logic pass);
        logic [17:0] v;
        v = 18'($urandom) | 18'h1;
        bus.pad_iw = v;
        #1;
        chk(tag, 32'(bus.prj_iw), pass ? 32'(v) : 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ctrl_sel_rst = 1'b0; ctrl_sel_inc = 1'b0; ctrl_ena = 1'b0;
        bus.pad_iw = '0; bus.prj_ow = '0;

        // 1. reset with inputs toggling
        for (int i = 0; i < 2; i++) begin
            ctrl_sel_rst = 1'($urandom); ctrl_sel_inc = 1'($urandom); ctrl_ena = 1'($urandom);
            bus.pad_iw = 18'($urandom);
            for (int k = 0; k < N_PROJ; k++) bus.prj_ow[k*24 +: 24] = 24'($urandom);
            tick(1);
        end
        chk("rst_cur_sel", 32'(cur_sel), 32'h0);
        chk("rst_prj_ena", 32'(bus.prj_ena), 32'h0);
        chk("rst_active",  32'(active), 32'h0);
        chk("rst_prj_iw",  32'(bus.prj_iw), 32'h0);
        chk("rst_pad_ow",  32'(bus.pad_ow), 32'h0);
        ctrl_sel_rst = 1'b0; ctrl_sel_inc = 1'b0; ctrl_ena = 1'b0;
        rst = 1'b0;
        tick(3);

        // 2. select slot 3 and enable
        selrst_pulse();
        repeat (3) inc_pulse();
        chk("sel3_cur_sel", 32'(cur_sel), 32'h3);
        ctrl_ena = 1'b1;
        tick(5);
        chk("sel3_settle_early", 32'(bus.prj_ena), 32'h0);
        tick(1);
        chk("sel3_prj_ena", 32'(bus.prj_ena), 32'h08);
        chk("sel3_active",  32'(active), 32'h1);
        iw_step("sel3_prj_iw_a", 1'b1);
        iw_step("sel3_prj_iw_b", 1'b1);
        for (int i = 0; i < 3; i++) ow_step("sel3_pad_ow", 3);

        // 3. inc edge while active
        ctrl_sel_inc = 1'b1;
        tick(2);
        chk("inc_before_cur_sel", 32'(cur_sel), 32'h3);
        chk("inc_before_prj_ena", 32'(bus.prj_ena), 32'h08);
        tick(1);
        chk("inc_cur_sel", 32'(cur_sel), 32'h4);
        chk("inc_prj_ena", 32'(bus.prj_ena), 32'h0);
        ctrl_sel_inc = 1'b0;
        tick(10);
        chk("inc_no_rearm", 32'(bus.prj_ena), 32'h0);
        ctrl_ena = 1'b0; tick(4);
        ctrl_ena = 1'b1; tick(5);
        chk("rearm_early", 32'(bus.prj_ena), 32'h0);
        tick(1);
        chk("rearm_prj_ena", 32'(bus.prj_ena), 32'h10);
        ow_step("sel4_pad_ow", 4);

        // 4. out-of-range select and saturation
        ctrl_ena = 1'b0; tick(4);
        selrst_pulse();
        repeat (12) inc_pulse();
        chk("oor_cur_sel", 32'(cur_sel), 32'd12);
        ctrl_ena = 1'b1; tick(10);
        chk("oor_prj_ena", 32'(bus.prj_ena), 32'h0);
        chk("oor_active",  32'(active), 32'h0);
        iw_step("oor_prj_iw", 1'b0);
        ow_step("oor_pad_ow", -1);
        repeat (20) inc_pulse();
        chk("sat_cur_sel", 32'(cur_sel), 32'd15);

        // 5. sel_rst + inc together during ARMING
        ctrl_ena = 1'b0; tick(4);
        selrst_pulse();
        repeat (2) inc_pulse();
        chk("arm_cur_sel", 32'(cur_sel), 32'h2);
        ctrl_ena = 1'b1; tick(2);
        ctrl_sel_rst = 1'b1; ctrl_sel_inc = 1'b1;
        seen = '0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen = seen | {bus.prj_ena, active};
            if (i == 2) begin ctrl_sel_rst = 1'b0; ctrl_sel_inc = 1'b0; end
        end
        chk("arm_abort_cur_sel", 32'(cur_sel), 32'h0);
        chk("arm_abort_never_ena", 32'(seen), 32'h0);

        // 6. synchronous reset mid-ACTIVE
        ctrl_ena = 1'b0; tick(4);
        inc_pulse();
        chk("s1_cur_sel", 32'(cur_sel), 32'h1);
        ctrl_ena = 1'b1; tick(5);
        chk("s1_early", 32'(bus.prj_ena), 32'h0);
        tick(1);
        chk("s1_prj_ena", 32'(bus.prj_ena), 32'h02);
        ow_step("s1_pad_ow", 1);
        rst = 1'b1;
        tick(1);
        chk("midrst_prj_ena", 32'(bus.prj_ena), 32'h0);
        chk("midrst_pad_ow",  32'(bus.pad_ow), 32'h0);
        chk("midrst_cur_sel", 32'(cur_sel), 32'h0);
        chk("midrst_active",  32'(active), 32'h0);
        chk("midrst_prj_iw",  32'(bus.prj_iw), 32'h0);
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
